// File: rtl/dot11_tx_bits.sv
// 802.11 legacy transmit bit-domain encoder: SIGNAL field, scrambler and rate-1/2 K=7 convolutional coder.
// Optional build macro TX_SCRAMBLER_BYPASS_EN adds a scram_bypass input latched at start.
module dot11_tx_bits #(
  parameter logic [6:0] DEFAULT_SEED = 7'h5D
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        start,
  input  logic [3:0]  rate,
  input  logic [11:0] len,
  input  logic [6:0]  scram_seed,
  input  logic [7:0]  byte_in,
  input  logic        byte_in_valid,
  output logic        byte_in_ready,
  output logic [1:0]  coded_out,
  output logic        coded_out_valid,
  input  logic        coded_out_ready,
  output logic        busy,
  output logic        done,
  output logic        rate_err,
  output logic [2:0]  state
`ifdef TX_SCRAMBLER_BYPASS_EN
  ,
  input  logic        scram_bypass
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SIGNAL  = 3'd1,
    S_SERVICE = 3'd2,
    S_DATA    = 3'd3,
    S_TAIL    = 3'd4,
    S_PAD     = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] len_q;
  logic [6:0]  seed_q;
  logic [23:0] sig_sr;
  logic [15:0] bit_cnt;
  logic [15:0] data_bits_q;
  logic [6:0]  scram;
  logic [5:0]  hist;
  logic [7:0]  byte_sr;
  logic [3:0]  bits_left;
  logic        done_q;
  logic        rate_err_q;
`ifdef TX_SCRAMBLER_BYPASS_EN
  logic        bypass_q;
`endif

  logic [15:0] n_dbps;
  logic        rate_ok;
  logic [15:0] frame_bits;
  logic [15:0] n_sym;
  logic [15:0] data_bits;
  logic [23:0] sig_word;
  logic        start_ok;
  logic        start_bad;

  logic        raw_bit;
  logic        bit_avail;
  logic        scram_active;
  logic        scram_apply;
  logic        scram_fb;
  logic        enc_in;
  logic        code_a;
  logic        code_b;
  logic        accept;
  logic        frame_end;

  logic [15:0] len_bits;
  logic        svc_last;
  logic        data_last;
  logic        tail_last;
  logic        pad_needed;
  logic        pad_last;

  // Start-time decode: data bits per symbol and the padded data-field length.
  always_comb begin
    n_dbps = 16'd0;
    case (rate)
      4'b1011: n_dbps = 16'd24;
      4'b1111: n_dbps = 16'd36;
      4'b1010: n_dbps = 16'd48;
      4'b1110: n_dbps = 16'd72;
      4'b1001: n_dbps = 16'd96;
      4'b1101: n_dbps = 16'd144;
      4'b1000: n_dbps = 16'd192;
      4'b1100: n_dbps = 16'd216;
      default: n_dbps = 16'd0;
    endcase
    rate_ok    = (n_dbps != 16'd0);
    frame_bits = 16'd22 + {1'b0, len, 3'b000};
    n_sym      = (frame_bits + n_dbps - 16'd1) / (rate_ok ? n_dbps : 16'd1);
    data_bits  = n_sym * n_dbps;
  end

  // R1 is rate[0] and leaves first, so the rate code sits unreversed in the low nibble.
  assign sig_word  = {6'b000000, ^{rate, len}, len, 1'b0, rate};
  assign start_ok  = enable & start & (state_q == S_IDLE) & rate_ok;
  assign start_bad = enable & start & (state_q == S_IDLE) & ~rate_ok;

  assign len_bits   = {1'b0, len_q, 3'b000};
  assign svc_last   = (bit_cnt == 16'd15);
  assign data_last  = (bit_cnt == 16'd15 + len_bits);
  assign tail_last  = (bit_cnt == 16'd21 + len_bits);
  assign pad_needed = (data_bits_q != 16'd22 + len_bits);
  assign pad_last   = (bit_cnt == data_bits_q - 16'd1);

  always_comb begin
    raw_bit      = 1'b0;
    bit_avail    = 1'b0;
    scram_active = 1'b0;
    case (state_q)
      S_SIGNAL: begin
        raw_bit   = sig_sr[0];
        bit_avail = 1'b1;
      end
      S_SERVICE: begin
        bit_avail    = 1'b1;
        scram_active = 1'b1;
      end
      S_DATA: begin
        raw_bit      = byte_sr[0];
        bit_avail    = (bits_left != 4'd0);
        scram_active = 1'b1;
      end
      S_TAIL, S_PAD: begin
        bit_avail    = 1'b1;
        scram_active = 1'b1;
      end
      default: begin
        bit_avail = 1'b0;
      end
    endcase
`ifdef TX_SCRAMBLER_BYPASS_EN
    scram_apply = scram_active & ~bypass_q;
`else
    scram_apply = scram_active;
`endif
    scram_fb = scram[6] ^ scram[3];
    if (state_q == S_TAIL) begin
      enc_in = 1'b0;
    end else if (scram_apply) begin
      enc_in = raw_bit ^ scram_fb;
    end else begin
      enc_in = raw_bit;
    end
    code_a = enc_in ^ hist[1] ^ hist[2] ^ hist[4] ^ hist[5];
    code_b = enc_in ^ hist[0] ^ hist[1] ^ hist[2] ^ hist[5];
  end

  assign coded_out_valid = enable & bit_avail;
  assign coded_out       = coded_out_valid ? {code_b, code_a} : 2'b00;
  assign accept          = coded_out_valid & coded_out_ready;
  assign byte_in_ready   = enable & (state_q == S_DATA) & (bits_left == 4'd0);

  always_comb begin
    state_d   = state_q;
    frame_end = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) state_d = S_SIGNAL;
      end
      S_SIGNAL: begin
        if (accept && bit_cnt == 16'd23) state_d = S_SERVICE;
      end
      S_SERVICE: begin
        if (accept && svc_last) state_d = (len_q == 12'd0) ? S_TAIL : S_DATA;
      end
      S_DATA: begin
        if (accept && data_last) state_d = S_TAIL;
      end
      S_TAIL: begin
        if (accept && tail_last) begin
          if (pad_needed) begin
            state_d = S_PAD;
          end else begin
            state_d   = S_IDLE;
            frame_end = 1'b1;
          end
        end
      end
      S_PAD: begin
        if (accept && pad_last) begin
          state_d   = S_IDLE;
          frame_end = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // bit_cnt restarts at SERVICE entry and then runs through DATA, TAIL and PAD.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= 12'd0;
      seed_q      <= 7'd0;
      sig_sr      <= 24'd0;
      bit_cnt     <= 16'd0;
      data_bits_q <= 16'd0;
      scram       <= 7'd0;
      hist        <= 6'd0;
      byte_sr     <= 8'd0;
      bits_left   <= 4'd0;
      done_q      <= 1'b0;
      rate_err_q  <= 1'b0;
`ifdef TX_SCRAMBLER_BYPASS_EN
      bypass_q    <= 1'b0;
`endif
    end else begin
      done_q     <= 1'b0;
      rate_err_q <= 1'b0;
      if (enable) begin
        state_q    <= state_d;
        done_q     <= frame_end;
        rate_err_q <= start_bad;
        if (start_ok) begin
          len_q       <= len;
          seed_q      <= (scram_seed == 7'd0) ? DEFAULT_SEED : scram_seed;
          sig_sr      <= sig_word;
          bit_cnt     <= 16'd0;
          data_bits_q <= data_bits;
          hist        <= 6'd0;
          bits_left   <= 4'd0;
`ifdef TX_SCRAMBLER_BYPASS_EN
          bypass_q    <= scram_bypass;
`endif
        end
        if (accept) begin
          hist <= {hist[4:0], enc_in};
          if (state_q == S_SIGNAL) begin
            sig_sr <= sig_sr >> 1;
            if (bit_cnt == 16'd23) begin
              bit_cnt <= 16'd0;
              scram   <= seed_q;
            end else begin
              bit_cnt <= bit_cnt + 16'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
            if (scram_active) scram <= {scram[5:0], scram_fb};
          end
          if (state_q == S_DATA) begin
            byte_sr   <= byte_sr >> 1;
            bits_left <= bits_left - 4'd1;
          end
        end
        if (byte_in_valid && byte_in_ready) begin
          byte_sr   <= byte_in;
          bits_left <= 4'd8;
        end
      end
    end
  end

  assign state    = state_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign rate_err = rate_err_q;

endmodule

// File: tb/tb_dot11_tx_bits.sv
// Self-checking bench for dot11_tx_bits: directed frames plus randomized frames against a
// sequence-level reference model of SIGNAL, scrambler and convolutional coder.
module tb_dot11_tx_bits;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        start;
  logic [3:0]  rate;
  logic [11:0] len;
  logic [6:0]  scram_seed;
  logic [7:0]  byte_in;
  logic        byte_in_valid;
  logic        byte_in_ready;
  logic [1:0]  coded_out;
  logic        coded_out_valid;
  logic        coded_out_ready;
  logic        busy;
  logic        done;
  logic        rate_err;
  logic [2:0]  state;
`ifdef TX_SCRAMBLER_BYPASS_EN
  logic        scram_bypass = 1'b0;
`endif

  dot11_tx_bits dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .start(start),
    .rate(rate),
    .len(len),
    .scram_seed(scram_seed),
    .byte_in(byte_in),
    .byte_in_valid(byte_in_valid),
    .byte_in_ready(byte_in_ready),
    .coded_out(coded_out),
    .coded_out_valid(coded_out_valid),
    .coded_out_ready(coded_out_ready),
    .busy(busy),
    .done(done),
    .rate_err(rate_err),
    .state(state)
`ifdef TX_SCRAMBLER_BYPASS_EN
    ,
    .scram_bypass(scram_bypass)
`endif
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  psdu[$];
  logic [1:0]  exp_q[$];
  logic [1:0]  got_q[$];
  logic [1:0]  saved_q[$];
  logic [3:0]  rate_tbl [8] = '{4'b1011, 4'b1111, 4'b1010, 4'b1110,
                                4'b1001, 4'b1101, 4'b1000, 4'b1100};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int ndbpsOf(input logic [3:0] r);
    case (r)
      4'b1011: return 24;
      4'b1111: return 36;
      4'b1010: return 48;
      4'b1110: return 72;
      4'b1001: return 96;
      4'b1101: return 144;
      4'b1000: return 192;
      4'b1100: return 216;
      default: return 0;
    endcase
  endfunction

  task automatic makePsdu(input int l);
    psdu = {};
    for (int i = 0; i < l; i++) psdu.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference: whole-frame bit list, then convolution over that list with the two generator tap sets.
  task automatic buildExpected(input logic [3:0] r, input logic [11:0] l, input logic [6:0] sd);
    bit         x[$];
    bit         par, fb, raw, a, b, xm1, xm2, xm3, xm5, xm6;
    int         nd, total, nbits;
    logic [6:0] s;
    logic [7:0] by;
    nd    = ndbpsOf(r);
    nbits = 8 * int'(l);
    total = ((22 + nbits + nd - 1) / nd) * nd;
    x = {};
    for (int i = 0; i < 4; i++) x.push_back(r[i]);
    x.push_back(1'b0);
    for (int i = 0; i < 12; i++) x.push_back(l[i]);
    par = 1'b0;
    for (int i = 0; i < 17; i++) par = par ^ x[i];
    x.push_back(par);
    for (int i = 0; i < 6; i++) x.push_back(1'b0);
    s = (sd == 7'd0) ? 7'h5D : sd;
    for (int k = 0; k < total; k++) begin
      raw = 1'b0;
      if (k >= 16 && k < 16 + nbits) begin
        by  = psdu[(k - 16) / 8];
        raw = by[(k - 16) % 8];
      end
      fb = s[6] ^ s[3];
      if (k >= 16 + nbits && k < 22 + nbits) x.push_back(1'b0);
      else x.push_back(raw ^ fb);
      s = {s[5:0], fb};
    end
    exp_q = {};
    for (int n = 0; n < x.size(); n++) begin
      xm1 = (n >= 1) ? x[n-1] : 1'b0;
      xm2 = (n >= 2) ? x[n-2] : 1'b0;
      xm3 = (n >= 3) ? x[n-3] : 1'b0;
      xm5 = (n >= 5) ? x[n-5] : 1'b0;
      xm6 = (n >= 6) ? x[n-6] : 1'b0;
      a = x[n] ^ xm2 ^ xm3 ^ xm5 ^ xm6;
      b = x[n] ^ xm1 ^ xm2 ^ xm3 ^ xm6;
      exp_q.push_back({b, a});
    end
  endtask

  // Inverts the A output of the coder to recover the first 24 input bits.
  function automatic logic [23:0] decodeSignal();
    logic [23:0] y;
    logic [1:0]  p;
    y = 24'd0;
    for (int n = 0; n < 24; n++) begin
      p = (n < got_q.size()) ? got_q[n] : 2'b00;
      y[n] = p[0] ^ ((n >= 2) ? y[n-2] : 1'b0) ^ ((n >= 3) ? y[n-3] : 1'b0)
                  ^ ((n >= 5) ? y[n-5] : 1'b0) ^ ((n >= 6) ? y[n-6] : 1'b0);
    end
    return y;
  endfunction

  // ready_mode: 0 always ready, 1 toggling, 2 random. Negative stall/reset/gap arguments disable them.
  task automatic applyStimulus(input logic [3:0] r, input logic [11:0] l, input logic [6:0] sd,
                               input int ready_mode, input int stall_byte, input int stall_len,
                               input int reset_pair, input int en_gap, input bit mid_start,
                               output int done_cnt, output bit busy_bad);
    int         idx, cyc, stalled, pairs, dn;
    bit         finished, prev_stuck, stall_now;
    logic [1:0] prev_pair;
    got_q = {};
    idx = 0; cyc = 0; stalled = 0; pairs = 0;
    finished = 1'b0; prev_stuck = 1'b0; prev_pair = 2'b00;
    done_cnt = 0; busy_bad = 1'b0;
    @(negedge clock);
    rate = r; len = l; scram_seed = sd; start = 1'b1;
    byte_in_valid = 1'b0; coded_out_ready = 1'b0;
    @(negedge clock);
    while (!finished && cyc < 5000) begin
      start = mid_start && (cyc == 10);
      if (start) begin
        rate = 4'b1101;
        len  = 12'd3;
      end
      case (ready_mode)
        0:       coded_out_ready = 1'b1;
        1:       coded_out_ready = (cyc % 2 == 0);
        default: coded_out_ready = ($urandom_range(0, 3) != 0);
      endcase
      enable = !(en_gap >= 0 && cyc >= en_gap && cyc < en_gap + 3);
      byte_in_valid = 1'b0;
      #1;
      stall_now = (stalled > 0 && stalled < stall_len) ||
                  (stalled == 0 && stall_len > 0 && idx == stall_byte && byte_in_ready === 1'b1);
      if (stall_now) begin
        stalled++;
      end else if (idx < int'(l)) begin
        byte_in = psdu[idx];
        byte_in_valid = 1'b1;
      end
      #1;
      if (stall_now) begin
        checkOutput("underflow_valid_low", coded_out_valid, 1'b0);
        checkOutput("underflow_byte_ready", byte_in_ready, 1'b1);
      end
      if (byte_in_valid && byte_in_ready === 1'b1) idx++;
      if (cyc == 0) checkOutput("first_valid_latency", coded_out_valid, 1'b1);
      if (!enable) checkOutput("enable_gap_valid", coded_out_valid, 1'b0);
      if (coded_out_valid === 1'b1 && prev_stuck) checkOutput("hold_stable", coded_out, prev_pair);
      prev_stuck = (coded_out_valid === 1'b1) && (coded_out_ready === 1'b0);
      prev_pair  = coded_out;
      if (coded_out_valid === 1'b1 && coded_out_ready === 1'b1) begin
        got_q.push_back(coded_out);
        pairs++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        checkOutput("busy_falls_with_done", busy, 1'b0);
        finished = 1'b1;
      end else if (busy !== 1'b1) begin
        busy_bad = 1'b1;
      end
      if (!finished && reset_pair >= 0 && pairs == reset_pair) begin
        reset = 1'b1;
        byte_in_valid = 1'b0;
        @(negedge clock);
        #1;
        checkOutput("abort_state_idle", state, 3'd0);
        checkOutput("abort_busy_low", busy, 1'b0);
        checkOutput("abort_valid_low", coded_out_valid, 1'b0);
        reset = 1'b0;
        dn = (done === 1'b1) ? 1 : 0;
        repeat (5) begin
          @(negedge clock);
          #1;
          if (done === 1'b1) dn++;
        end
        checkOutput("abort_no_done", dn, 0);
        finished = 1'b1;
      end
      cyc++;
      @(negedge clock);
    end
    checkOutput("frame_finished_in_budget", finished, 1'b1);
    start = 1'b0;
    byte_in_valid = 1'b0;
    coded_out_ready = 1'b0;
    enable = 1'b1;
  endtask

  task automatic checkFrame(input string tag, input int done_cnt, input bit busy_bad);
    int bad;
    int n;
    bad = -1;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    checkOutput({tag, "_pair_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) begin
      if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    end
    checks++;
    assert (bad < 0) else begin
      errors++;
      $error("[TB] FAIL %s_stream pair %0d observed=%b expected=%b", tag, bad, got_q[bad], exp_q[bad]);
    end
    checkOutput({tag, "_done_pulses"}, done_cnt, 1);
    checkOutput({tag, "_busy_held"}, busy_bad, 1'b0);
  endtask

  initial begin
    int          dc;
    bit          bb;
    logic [3:0]  rr;
    logic [11:0] ll;
    logic [6:0]  ss;
    reset = 1'b1; enable = 1'b1; start = 1'b0; rate = 4'd0; len = 12'd0; scram_seed = 7'd0;
    byte_in = 8'd0; byte_in_valid = 1'b0; coded_out_ready = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    checkOutput("reset_state", state, 3'd0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_rate_err", rate_err, 1'b0);
    checkOutput("reset_valid", coded_out_valid, 1'b0);
    checkOutput("reset_coded", coded_out, 2'b00);
    checkOutput("reset_byte_ready", byte_in_ready, 1'b0);
    reset = 1'b0;

    $display("[TB] frame 1: rate 1011 len 1 seed 5D");
    makePsdu(1);
    buildExpected(4'b1011, 12'd1, 7'h5D);
    applyStimulus(4'b1011, 12'd1, 7'h5D, 0, -1, 0, -1, -1, 1'b0, dc, bb);
    checkFrame("f1", dc, bb);
    checkOutput("f1_total_pairs", got_q.size(), 72);
    checkOutput("f1_signal_bits", decodeSignal(), 24'h00002B);
    checkOutput("f1_impulse_first_pair", got_q[0], 2'b11);
    checkOutput("f1_zero_segment_pair18", got_q[18], 2'b00);
    checkOutput("f1_zero_segment_pair23", got_q[23], 2'b00);

    $display("[TB] invalid rate start");
    @(negedge clock);
    rate = 4'b0000; len = 12'd5; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    #1;
    checkOutput("rate_err_pulse", rate_err, 1'b1);
    checkOutput("rate_err_busy", busy, 1'b0);
    checkOutput("rate_err_valid", coded_out_valid, 1'b0);
    @(negedge clock);
    #1;
    checkOutput("rate_err_one_cycle", rate_err, 1'b0);
    checkOutput("rate_err_still_idle", state, 3'd0);

    $display("[TB] backpressure: rate 1011 len 4");
    makePsdu(4);
    buildExpected(4'b1011, 12'd4, 7'h2A);
    applyStimulus(4'b1011, 12'd4, 7'h2A, 0, -1, 0, -1, -1, 1'b0, dc, bb);
    checkFrame("bp_ready1", dc, bb);
    saved_q = got_q;
    applyStimulus(4'b1011, 12'd4, 7'h2A, 1, -1, 0, -1, -1, 1'b0, dc, bb);
    checkFrame("bp_toggle", dc, bb);
    checkOutput("bp_same_length", got_q.size(), saved_q.size());
    checkOutput("bp_same_last_pair", got_q[got_q.size()-1], saved_q[saved_q.size()-1]);

    $display("[TB] underflow: rate 1111 len 6");
    makePsdu(6);
    buildExpected(4'b1111, 12'd6, 7'h11);
    applyStimulus(4'b1111, 12'd6, 7'h11, 0, 3, 10, -1, -1, 1'b0, dc, bb);
    checkFrame("underflow", dc, bb);

    $display("[TB] reset at pair 30, then a clean frame");
    makePsdu(5);
    buildExpected(4'b1010, 12'd5, 7'h33);
    applyStimulus(4'b1010, 12'd5, 7'h33, 0, -1, 0, 30, -1, 1'b0, dc, bb);
    checkOutput("abort_done_count", dc, 0);
    makePsdu(5);
    buildExpected(4'b1010, 12'd5, 7'h47);
    applyStimulus(4'b1010, 12'd5, 7'h47, 0, -1, 0, -1, -1, 1'b0, dc, bb);
    checkFrame("after_reset", dc, bb);

    $display("[TB] empty PSDU with default seed");
    makePsdu(0);
    buildExpected(4'b1000, 12'd0, 7'd0);
    applyStimulus(4'b1000, 12'd0, 7'd0, 2, -1, 0, -1, -1, 1'b0, dc, bb);
    checkFrame("len0", dc, bb);

    $display("[TB] randomized frames");
    for (int i = 0; i < 8; i++) begin
      rr = rate_tbl[$urandom_range(0, 7)];
      ll = 12'($urandom_range(0, 24));
      ss = 7'($urandom_range(0, 127));
      makePsdu(int'(ll));
      buildExpected(rr, ll, ss);
      applyStimulus(rr, ll, ss, 2, -1, 0, -1, (i == 1) ? 20 : -1, (i == 2), dc, bb);
      checkFrame($sformatf("rand%0d", i), dc, bb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
